inv_rounds: RTL and testbench
=============================

// Module: inv_rounds
// PURPOSE
//  Iterative AES-128 inverse cipher: the decrypt counterpart of the Rounds encryption core.
//  Decrypts one 128-bit block, computing one round per clock. round_num tells the
//  key-schedule source which round key to drive on round_key in the current cycle.
//  Keys are consumed in descending order, K[NR] first and K[0] last.
//  The block sits between the key-expansion/key-store block and the data-path output stage.
// PARAMETERS
//  NR      10   number of rounds; only 10 (AES-128) supported, other values unsupported
// PORTS
//  clk          in   1        single clock, all state on rising edge
//  reset_n      in   1        asynchronous, active-low reset
//  start        in   1        begin decryption; sampled only in IDLE or DONE
//  cipher_text  in   [0:127]  ciphertext block; sampled on the accepted start edge only
//  round_key    in   [0:127]  round key K[round_num]; must be valid every cycle of an operation
//  dec_data     out  [0:127]  decrypted block; valid while valid_flag=1
//  round_num    out  [3:0]    index of the key required on round_key this cycle
//  valid_flag   out  1        dec_data holds a completed result
// BEHAVIOUR
//  Byte order
//   - bits [0:7] = byte 0; state is column-major (byte i at row i%4, column i/4).
//  Reset values
//   - state=IDLE, round_num=NR(10), dec_data=0, valid_flag=0, internal state register=0.
//  FSM: IDLE -> ROUND -> FINAL -> DONE
//   - IDLE: round_num=10. On start: state <= cipher_text ^ round_key (K10); round_num <= 9;
//     go to ROUND.
//   - ROUND (round_num 9..1): state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key).
//     Then round_num <= round_num-1. Leave ROUND for FINAL when round_num transitions 1->0.
//   - FINAL (round_num=0): dec_data <= InvSubBytes(InvShiftRows(state)) ^ round_key (K0);
//     valid_flag <= 1; round_num <= 10; go to DONE.
//   - DONE: dec_data and valid_flag held until the next accepted start. A start in DONE acts
//     exactly as in IDLE and clears valid_flag on that same edge.
//  Latency
//   - Accepted start on edge E0 gives valid_flag=1 after edge E10 (11 key cycles, K10..K0).
//  Arithmetic
//   - GF(2^8) with polynomial x^8+x^4+x^3+x+1.
//   - InvMixColumns coefficients {0e,0b,0d,09}; products built from chained xtime.
//  Boundaries
//   - start while in ROUND/FINAL: ignored, no restart.
//   - start held high continuously: a new operation begins on every DONE cycle.
//   - reset_n low at any time, including mid-operation: all outputs return to reset values
//     immediately (asynchronous).
//   - cipher_text changes after acceptance: no effect on the running operation.
// STRUCTURE
//  - aes_pkg: NR, the 256-entry INV_SBOX constant table, and functions xtime, gmul,
//    inv_shift_rows, inv_mix_column.
//  - Sub-module inv_sub_bytes: 16 parallel inverse S-box lookups, 128-bit in/out,
//    purely combinational. Instantiated once and shared by the ROUND and FINAL paths.
//  - Top level contains the FSM, the round counter, the state register and the output register.
// TESTING
//  1. FIPS-197 C.1: cipher_text=69c4e0d86a7b0430d8cdb78070b4c55a, keys K10..K0 of key
//     000102..0f (K10=13111d7fe3944a17f307a78b4d2b30c5, K0=000102030405060708090a0b0c0d0e0f)
//     -> dec_data=00112233445566778899aabbccddeeff, valid_flag=1 after edge E10.
//  2. Zero-key schedule, keys driven in reverse order (K10=b4ef5bcb3e92e21123e951cf6f8f188e
//     .. K0=0), cipher_text=c7d12419489e3b6233a2c5a7f4563172
//     -> dec_data=00000101030307070f0f1f1f3f3f7f7f.
//  3. round_num trace across one operation -> 10 (idle), 9,8,..,1,0, then 10 in DONE;
//     valid_flag low throughout the operation.
//  4. Pulse start again at round_num=5 with a different cipher_text
//     -> ignored; result still equals vector 1.
//  5. reset_n low at round_num=4, then release -> round_num=10, valid_flag=0, dec_data=0;
//     a new start then yields the correct result.
//  6. start held high from DONE with a second vector -> valid_flag drops on the restart edge,
//     second result valid 11 edges later; loopback Rounds->inv_rounds returns plaintext.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: round count, FSM states, inverse S-box
// table and the GF(2^8) helpers used by the inverse round datapath.
package aes_pkg;

   localparam int NR = 10;

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      FINAL,
      DONE
   } inv_state_e;

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Row r rotates right by r; byte index is row + 4*column.
   function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
      logic [0:127] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[8*(row+4*c) +: 8] = s[8*(row+4*((c-row+4)%4)) +: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [0:31] inv_mix_column(input logic [0:31] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[0:7];
      a1 = col[8:15];
      a2 = col[16:23];
      a3 = col[24:31];
      return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
              gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
              gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
              gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
   endfunction

endpackage

// File: rtl/inv_sub_bytes.sv
// Sixteen parallel inverse S-box lookups over a 128-bit AES state; purely combinational.
module inv_sub_bytes
   import aes_pkg::*;
(
   input  logic [0:127] data_i,
   output logic [0:127] data_o
);

   for (genvar i = 0; i < 16; i++) begin : g_byte
      assign data_o[8*i +: 8] = INV_SBOX[data_i[8*i +: 8]];
   end

endmodule

// File: rtl/inv_rounds.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys requested
// through round_num in descending order (K[NR] first, K[0] last).
module inv_rounds #(
   parameter int NR = aes_pkg::NR
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [0:127] cipher_text,
   input  logic [0:127] round_key,
   output logic [0:127] dec_data,
   output logic [3:0]   round_num,
   output logic         valid_flag
);
   import aes_pkg::*;

   inv_state_e   fsm_q, fsm_d;
   logic [0:127] block_q, block_d;
   logic [3:0]   round_q, round_d;
   logic [0:127] dec_q, dec_d;
   logic         valid_q, valid_d;

   logic [0:127] shifted;
   logic [0:127] subbed;
   logic [0:127] keyed;
   logic [0:127] mixed;

   // One S-box bank serves both the middle rounds and the final round.
   assign shifted = inv_shift_rows(block_q);

   inv_sub_bytes u_inv_sub_bytes (
      .data_i (shifted),
      .data_o (subbed)
   );

   assign keyed = subbed ^ round_key;

   always_comb begin
      mixed = '0;
      for (int c = 0; c < 4; c++) begin
         mixed[32*c +: 32] = inv_mix_column(keyed[32*c +: 32]);
      end
   end

   always_comb begin
      fsm_d   = fsm_q;
      block_d = block_q;
      round_d = round_q;
      dec_d   = dec_q;
      valid_d = valid_q;
      case (fsm_q)
         IDLE, DONE: begin
            if (start) begin
               block_d = cipher_text ^ round_key;
               round_d = 4'(NR - 1);
               valid_d = 1'b0;
               fsm_d   = ROUND;
            end
         end
         ROUND: begin
            block_d = mixed;
            round_d = round_q - 4'd1;
            if (round_q == 4'd1) fsm_d = FINAL;
         end
         FINAL: begin
            dec_d   = keyed;
            valid_d = 1'b1;
            round_d = 4'(NR);
            fsm_d   = DONE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q   <= IDLE;
         block_q <= '0;
         round_q <= 4'(NR);
         dec_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         block_q <= block_d;
         round_q <= round_d;
         dec_q   <= dec_d;
         valid_q <= valid_d;
      end
   end

   assign dec_data   = dec_q;
   assign round_num  = round_q;
   assign valid_flag = valid_q;

endmodule

// File: tb/tb_inv_rounds.sv
// Self-checking bench for inv_rounds: directed FIPS-197 and zero-key vectors with a
// result scoreboard, plus cycle-level checks of round_num, latency, restart and reset.
module tb_inv_rounds;

   localparam logic [0:127] CT1      = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [0:127] PT1      = 128'h00112233445566778899aabbccddeeff;
   localparam logic [0:127] CT2      = 128'hc7d12419489e3b6233a2c5a7f4563172;
   localparam logic [0:127] PT2      = 128'h00000101030307070f0f1f1f3f3f7f7f;
   localparam logic [0:127] CT_OTHER = 128'hdeadbeef0123456789abcdeffedcba98;

   localparam logic [0:127] FIPS_KEYS [11] = '{
      128'h000102030405060708090a0b0c0d0e0f,
      128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
      128'hb692cf0b643dbdf1be9bc5006830b3fe,
      128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
      128'h47f7f7bc95353e03f96c32bcfd058dfd,
      128'h3caaa3e8a99f9deb50f3af57adf622aa,
      128'h5e390f7df7a69296a7553dc10aa31f6b,
      128'h14f9701ae35fe28c440adf4d4ea9c026,
      128'h47438735a41c65b9e016baf4aebf7ad2,
      128'h549932d1f08557681093ed9cbe2c974e,
      128'h13111d7fe3944a17f307a78b4d2b30c5
   };

   localparam logic [0:127] ZERO_KEYS [11] = '{
      128'h00000000000000000000000000000000,
      128'h62636363626363636263636362636363,
      128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
      128'h90973450696ccffaf2f457330b0fac99,
      128'hee06da7b876a1581759e42b27e91ee2b,
      128'h7f2e2b88f8443e098dda7cbbf34b9290,
      128'hec614b851425758c99ff09376ab49ba7,
      128'h217517873550620bacaf6b3cc61bf09b,
      128'h0ef903333ba9613897060a04511dfa9f,
      128'hb1d4d8e28a7db9da1d7bb3de4c664941,
      128'hb4ef5bcb3e92e21123e951cf6f8f188e
   };

   logic         clk;
   logic         reset_n;
   logic         start;
   logic [0:127] cipher_text;
   logic [0:127] round_key;
   logic [0:127] dec_data;
   logic [3:0]   round_num;
   logic         valid_flag;
   logic         keySet;

   int           checks;
   int           fails;
   logic [0:127] expQ [$];
   logic         prevValid;

   inv_rounds dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .cipher_text (cipher_text),
      .round_key   (round_key),
      .dec_data    (dec_data),
      .round_num   (round_num),
      .valid_flag  (valid_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Acts as the key store: serves K[round_num] from the selected schedule.
   always_comb begin
      round_key = '0;
      if (round_num <= 4'd10) round_key = keySet ? ZERO_KEYS[round_num] : FIPS_KEYS[round_num];
   end

   // Scoreboard monitor: every rising valid_flag consumes one expected result.
   always @(negedge clk) begin
      if (reset_n && valid_flag && !prevValid) begin
         checks++;
         if (expQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_result: got %h, expected no result", dec_data);
         end else begin
            logic [0:127] exp;
            exp = expQ.pop_front();
            if (dec_data !== exp) begin
               fails++;
               $display("[TB] FAIL dec_data: got %h, expected %h", dec_data, exp);
            end
         end
      end
      prevValid = valid_flag;
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [0:127] ct, input logic ks, input logic [0:127] exp);
      cipher_text = ct;
      keySet      = ks;
      start       = 1'b1;
      expQ.push_back(exp);
      stepEdge();
      start = 1'b0;
   endtask

   // Runs the remaining edges of an operation and checks valid rises exactly on the last.
   task automatic finishOp(input string name, input int edges);
      repeat (edges - 1) stepEdge();
      checkOutput({name, "_busy"}, 128'(valid_flag), 128'(0));
      stepEdge();
      checkOutput({name, "_valid"}, 128'(valid_flag), 128'(1));
   endtask

   initial begin
      checks      = 0;
      fails       = 0;
      prevValid   = 1'b0;
      reset_n     = 1'b0;
      start       = 1'b0;
      keySet      = 1'b0;
      cipher_text = '0;

      // Reset state
      repeat (2) stepEdge();
      checkOutput("reset_round_num", 128'(round_num), 128'(10));
      checkOutput("reset_valid", 128'(valid_flag), 128'(0));
      checkOutput("reset_dec_data", dec_data, 128'(0));
      reset_n = 1'b1;
      stepEdge();
      checkOutput("idle_round_num", 128'(round_num), 128'(10));

      // FIPS-197 vector with full round_num trace
      cipher_text = CT1;
      keySet      = 1'b0;
      start       = 1'b1;
      expQ.push_back(PT1);
      for (int k = 0; k <= 10; k++) begin
         stepEdge();
         start = 1'b0;
         checkOutput($sformatf("trace_round_E%0d", k), 128'(round_num), 128'((k == 10) ? 10 : 9 - k));
         checkOutput($sformatf("trace_valid_E%0d", k), 128'(valid_flag), 128'((k == 10) ? 1 : 0));
      end
      stepEdge();
      checkOutput("done_hold_valid", 128'(valid_flag), 128'(1));
      checkOutput("done_hold_data", dec_data, PT1);

      // Start pulse mid-operation is ignored
      applyStimulus(CT1, 1'b0, PT1);
      repeat (4) stepEdge();
      checkOutput("mid_round_num", 128'(round_num), 128'(5));
      cipher_text = CT_OTHER;
      start       = 1'b1;
      stepEdge();
      start = 1'b0;
      checkOutput("ignored_start_round", 128'(round_num), 128'(4));
      finishOp("ignored_start", 5);

      // Zero-key schedule
      applyStimulus(CT2, 1'b1, PT2);
      cipher_text = CT_OTHER;
      finishOp("zero_key", 10);

      // Asynchronous reset mid-operation
      applyStimulus(CT1, 1'b0, PT1);
      repeat (5) stepEdge();
      checkOutput("pre_reset_round", 128'(round_num), 128'(4));
      #2;
      reset_n = 1'b0;
      expQ.delete();
      #1;
      checkOutput("async_reset_round", 128'(round_num), 128'(10));
      checkOutput("async_reset_valid", 128'(valid_flag), 128'(0));
      checkOutput("async_reset_data", dec_data, 128'(0));
      stepEdge();
      reset_n = 1'b1;
      stepEdge();
      applyStimulus(CT1, 1'b0, PT1);
      finishOp("after_reset", 10);

      // Start held high from DONE: back-to-back operations
      cipher_text = CT2;
      keySet      = 1'b1;
      start       = 1'b1;
      expQ.push_back(PT2);
      expQ.push_back(PT2);
      stepEdge();
      checkOutput("restart_valid_drop", 128'(valid_flag), 128'(0));
      checkOutput("restart_round", 128'(round_num), 128'(9));
      finishOp("held_start_1", 10);
      stepEdge();
      checkOutput("restart2_valid_drop", 128'(valid_flag), 128'(0));
      finishOp("held_start_2", 10);
      start = 1'b0;
      stepEdge();
      checkOutput("final_hold_valid", 128'(valid_flag), 128'(1));
      checkOutput("final_hold_round", 128'(round_num), 128'(10));
      checkOutput("final_hold_data", dec_data, PT2);

      checkOutput("scoreboard_drained", 128'(expQ.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
